// File: rtl/jtag_user_dr_bridge.sv
// USER data register in the tck domain: host DR frames push words into a
// first-word-fall-through FIFO, and each Capture-DR returns solver result/status.
module jtag_user_dr_bridge #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          tck,
  input  logic                          test_logic_reset,
  input  logic                          tdi,
  output logic                          tdo,
  input  logic                          ir_is_user,
  input  logic                          capture_dr,
  input  logic                          shift_dr,
  input  logic                          update_dr,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  input  logic                          result_valid,
  input  logic [RESULT_WIDTH-1:0]       result_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int SR_W = (DATA_WIDTH + 1 > RESULT_WIDTH + 2) ? DATA_WIDTH + 1 : RESULT_WIDTH + 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  logic [SR_W-1:0]       sr;
  logic [SR_W-1:0]       cap_word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;

  // Stream handshake: a word transfers on every cycle where out_valid and
  // out_ready are both high; out_valid/out_data hold while out_ready is low.
  assign full      = (level == LW'(FIFO_DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = mem[rptr];
  assign pop       = out_valid & out_ready;
  assign push_req  = ir_is_user & update_dr & sr[DATA_WIDTH];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);

  assign tdo        = ir_is_user ? sr[0] : tdi;
  assign fifo_level = level;

  always_comb begin
    cap_word = '0;
    cap_word[RESULT_WIDTH+1:0] = {overflow, result_valid, result_data};
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      sr <= '0;
    end else if (ir_is_user) begin
      if (capture_dr) begin
        sr <= cap_word;
      end else if (shift_dr) begin
        sr <= {tdi, sr[SR_W-1:1]};
      end
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge tck) begin
    if (push_ok && !test_logic_reset) begin
      mem[wptr] <= sr[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push_ok && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push_ok) begin
        level <= level - LW'(1);
      end
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_user_dr_bridge.sv
// Bench for jtag_user_dr_bridge: directed host frames plus random traffic,
// checked against a queue-based FIFO model and captured-status expectations.
module tb_jtag_user_dr_bridge;

  localparam int DATA_WIDTH   = 8;
  localparam int RESULT_WIDTH = 16;
  localparam int FIFO_DEPTH   = 16;
  localparam int SR_W = (DATA_WIDTH + 1 > RESULT_WIDTH + 2) ? DATA_WIDTH + 1 : RESULT_WIDTH + 2;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;

  logic                    tck;
  logic                    test_logic_reset;
  logic                    tdi;
  logic                    tdo;
  logic                    ir_is_user;
  logic                    capture_dr;
  logic                    shift_dr;
  logic                    update_dr;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_ready;
  logic                    result_valid;
  logic [RESULT_WIDTH-1:0] result_data;
  logic [LW-1:0]           fifo_level;
  logic                    overflow;

  jtag_user_dr_bridge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .tck             (tck),
    .test_logic_reset(test_logic_reset),
    .tdi             (tdi),
    .tdo             (tdo),
    .ir_is_user      (ir_is_user),
    .capture_dr      (capture_dr),
    .shift_dr        (shift_dr),
    .update_dr       (update_dr),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .result_valid    (result_valid),
    .result_data     (result_data),
    .fifo_level      (fifo_level),
    .overflow        (overflow)
  );

  // ---------------- clock ----------------
  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  // ---------------- scoreboard / model ----------------
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic                  model_ovf;
  logic                  push_pend;
  logic [DATA_WIDTH-1:0] push_word;
  bit                    rand_ready;
  int                    ready_pct;
  int                    checks;
  int                    errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    check_val({tag, "_level"}, 32'(fifo_level), 32'(exp_q.size()));
    check_val({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    if (exp_q.size() != 0) check_val({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
  endtask

  // One clock cycle: apply the FIFO rules to the model, then let the DUT clock.
  task automatic tick();
    int n;
    bit pop;
    if (rand_ready) out_ready = ($urandom_range(0, 99) < ready_pct);
    n   = exp_q.size();
    pop = (n != 0) && out_ready;
    if (test_logic_reset) begin
      exp_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push_pend) begin
        if (n < FIFO_DEPTH || pop) exp_q.push_back(push_word);
        else model_ovf = 1'b1;
      end
    end
    @(posedge tck);
    @(negedge tck);
    push_pend = 1'b0;
  endtask

  // Capture, shift nbits of a host frame (checking the status read back), update.
  task automatic run_frame(input logic [DATA_WIDTH-1:0] d, input bit flag,
                           input int nbits, input bit ready_upd);
    logic [SR_W-1:0] frame;
    logic [SR_W-1:0] cap;
    logic [SR_W-1:0] sr_end;
    frame = '0;
    frame[DATA_WIDTH-1:0] = d;
    frame[DATA_WIDTH] = flag;
    cap = '0;
    cap[RESULT_WIDTH+1:0] = {model_ovf, result_valid, result_data};
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    check_outputs("capture");
    shift_dr = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      tdi = frame[i];
      #1;
      check_val("tdo_shift", 32'(tdo), 32'(cap[i]));
      tick();
    end
    shift_dr = 1'b0;
    check_outputs("shift");
    // After k shifts the register holds the unshifted status tail with the
    // frame bits stacked on top of it.
    sr_end = (cap >> nbits) | (frame << (SR_W - nbits));
    update_dr = 1'b1;
    push_pend = sr_end[DATA_WIDTH];
    push_word = sr_end[DATA_WIDTH-1:0];
    if (ready_upd) out_ready = 1'b1;
    tick();
    update_dr = 1'b0;
    if (ready_upd) out_ready = 1'b0;
    check_outputs("update");
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tick();
      check_outputs(tag);
    end
    check_val({tag, "_empty"}, 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    test_logic_reset = 1'b1;
    tick();
    tick();
    test_logic_reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0; errors = 0;
    model_ovf = 1'b0; push_pend = 1'b0; push_word = '0;
    rand_ready = 1'b0; ready_pct = 50;
    test_logic_reset = 1'b1; tdi = 1'b0; ir_is_user = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    out_ready = 1'b0; result_valid = 1'b0; result_data = '0;

    do_reset();
    check_outputs("reset");

    // Legacy passthrough
    for (int i = 0; i < 6; i++) begin
      tdi = 1'($urandom_range(0, 1));
      #1;
      check_val("passthru", 32'(tdo), 32'(tdi));
      tick();
    end
    check_outputs("passthru");

    ir_is_user = 1'b1;
    #1;
    check_val("tdo_reset_sr", 32'(tdo), 32'd0);

    // Push 0xA5, then pop it
    run_frame(8'hA5, 1'b1, SR_W, 1'b0);
    check_val("a5_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_outputs("a5_pop");

    // Flag clear: no push
    run_frame(8'h3C, 1'b0, SR_W, 1'b0);
    check_val("noflag_level", 32'(fifo_level), 32'd0);

    // Status read-back of a known result
    result_data = 16'h1234;
    result_valid = 1'b1;
    run_frame(8'h00, 1'b0, SR_W, 1'b0);

    // Fill past capacity: 17 pushes, the last one dropped
    for (int w = 0; w <= FIFO_DEPTH; w++) run_frame(DATA_WIDTH'(w), 1'b1, SR_W, 1'b0);
    check_val("fill_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check_val("fill_ovf", 32'(overflow), 32'd1);
    drain("drain1");

    // Full FIFO with a pop on the update cycle accepts the push
    do_reset();
    check_outputs("reset2");
    for (int w = 0; w < FIFO_DEPTH; w++) run_frame(DATA_WIDTH'(w + 8'h40), 1'b1, SR_W, 1'b0);
    run_frame(8'h77, 1'b1, SR_W, 1'b1);
    check_val("full_pp_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    check_val("full_pp_ovf", 32'(overflow), 32'd0);
    drain("drain2");

    // Random traffic: low pop rate first (to reach overflow), then mixed
    rand_ready = 1'b1;
    for (int it = 0; it < 200; it++) begin
      int nbits;
      int idle;
      ready_pct = (it < 100) ? 2 : 50;
      result_valid = 1'($urandom_range(0, 1));
      result_data  = RESULT_WIDTH'($urandom);
      nbits = ($urandom_range(0, 7) == 0) ? $urandom_range(1, SR_W - 1) : SR_W;
      run_frame(DATA_WIDTH'($urandom), ($urandom_range(0, 3) != 0), nbits, 1'b0);
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        tick();
        check_outputs("rand_idle");
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b0;

    // Reset in the middle of a shift with a non-empty FIFO
    run_frame(8'h5A, 1'b1, SR_W, 1'b0);
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    test_logic_reset = 1'b1;
    out_ready = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    shift_dr = 1'b0;
    out_ready = 1'b0;
    #1;
    check_outputs("midshift_reset");
    check_val("midshift_tdo", 32'(tdo), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_user_dr_bridge.md
Name: jtag_user_dr_bridge

Overview:
Parametrised successor to the JTAG user-logic stub, which only looped tdi back to tdo. It implements a real USER data register in the tck domain. Host shifts push words in; each push is delivered through a first-word-fall-through FIFO as a valid/ready stream to the puzzle solver. On every DR capture the solver's result and status are returned to the host.

Parameters:
DATA_WIDTH, 8, bits per input word pushed by the host
RESULT_WIDTH, 16, width of the solver result returned on capture
FIFO_DEPTH, 16, input FIFO entries; power of two, >= 2
SR_W, max(DATA_WIDTH+1, RESULT_WIDTH+2), DR shift-register length (derived, not overridable)

Ports:
tck  input  1  sole clock; all state on rising edge
test_logic_reset  input  1  synchronous, active-high reset
tdi  input  1  JTAG serial data in
tdo  output  1  JTAG serial data out
ir_is_user  input  1  USER instruction selected in IR
capture_dr  input  1  TAP in Capture-DR
shift_dr  input  1  TAP in Shift-DR
update_dr  input  1  TAP in Update-DR
out_valid  output  1  FIFO head word available
out_data  output  DATA_WIDTH  FIFO head word
out_ready  input  1  solver accepts head word
result_valid  input  1  solver result final
result_data  input  RESULT_WIDTH  solver result
fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (test_logic_reset=1 at a tck edge):
  - sr=0, FIFO empty, fifo_level=0, out_valid=0, overflow=0.
  - out_data don't-care while out_valid=0.
  - Reset has priority over every other event, including one mid-shift or with a simultaneous push/pop.
- tdo (combinational):
  - ir_is_user=1: tdo = sr[0].
  - ir_is_user=0: tdo = tdi (legacy passthrough).
- DR operations, each gated by ir_is_user=1; TAP states are mutually exclusive:
  - capture_dr: sr <= zero-extended {overflow, result_valid, result_data}; result_data in bits [RESULT_WIDTH-1:0].
  - shift_dr: sr <= {tdi, sr[SR_W-1:1]}; LSB first, one bit per cycle.
  - update_dr: if sr[DATA_WIDTH]=1 (push flag), request push of sr[DATA_WIDTH-1:0]; if the flag is 0, do nothing.
- Host frame, exactly SR_W bits in shift order:
  - data bit 0 .. DATA_WIDTH-1, then push flag, then zero padding.
  - The bits shifted out in the same frame are the captured status, LSB first.
  - Short frame (fewer than SR_W shifts): no special handling; sr content is whatever was shifted, and the push flag is evaluated as-is.
- FIFO (first-word fall-through):
  - out_valid = (fifo_level != 0); out_data = head entry.
  - pop = out_valid & out_ready.
  - Push accepted when fifo_level < FIFO_DEPTH, or when full with a pop in the same cycle.
  - Accepted push: word visible on out_data/out_valid the next cycle (latency 1 from the update_dr cycle) if the FIFO was empty.
  - Push + pop in the same cycle: level unchanged; order preserved.
  - Pop when empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH; fifo_level counts 0..FIFO_DEPTH.
- Overflow:
  - Full, no pop, push requested: word dropped; overflow <= 1 next cycle; FIFO contents unchanged.
  - overflow clears only on reset.
- out_data/out_valid stability:
  - Held stable while out_valid=1 and out_ready=0.
  - A push into a non-empty FIFO never changes the head.
- result_valid/result_data are sampled only at capture_dr. No synchroniser is required; the solver runs on tck.

Test Plan:
- Reset, then ir_is_user=0, toggle tdi -> tdo follows tdi; out_valid=0, fifo_level=0, overflow=0.
- Push 0xA5 (frame 1,0,1,0,0,1,0,1, flag 1, zero pad to SR_W=18), update_dr -> next cycle out_valid=1, out_data=0xA5, fifo_level=1; out_ready=1 one cycle -> fifo_level=0.
- Push frame with flag 0, data 0x3C -> no push; fifo_level stays 0.
- result_data=0x1234, result_valid=1, overflow=0; capture then 18 shifts -> tdo emits 0x1234 LSB first, then 1, then 0, then zeros.
- out_ready=0; push 0..16 (17 words) -> fifo_level=16, overflow=1, word 16 dropped. Then drain -> out_data sequence 0..15 in order.
- FIFO full, out_ready=1 on the update_dr cycle of a push of 0x77 -> level stays 16, overflow stays 0, 0x77 appears last. test_logic_reset asserted mid-shift -> all outputs return to reset values next cycle.
